// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, command-master state encoding and payload structs.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// 8-bit wait-state counter for the APB command master; built only with APB_MASTER_TIMEOUT_EN.
module apb_timeout_ctr (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       clear,
    input  logic       increment,
    input  logic [7:0] limit,
    output logic       expired_c
);

    logic [7:0] count_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_q <= 8'd0;
        end else if (clear) begin
            count_q <= 8'd0;
        end else if (increment) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Flags the wait cycle whose increment makes the count reach the limit.
    assign expired_c = increment && ((count_q + 8'd1) == limit);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master turning local commands into APB transfers.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..255");
    end

    apb_mst_state_e    state_q, state_d;
    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              rsp_timeout_d;
    logic [ADDR_W-1:0] paddr_d;
    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [DATA_W-1:0] pwdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic tmo_clear_c;
    logic tmo_inc_c;
    logic tmo_expired_c;

    apb_timeout_ctr u_timeout_ctr (
        .pclk      (pclk),
        .presetn   (presetn),
        .clear     (tmo_clear_c),
        .increment (tmo_inc_c),
        .limit     (TIMEOUT_LIMIT),
        .expired_c (tmo_expired_c)
    );
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        paddr_d       = paddr;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        pwdata_d      = pwdata;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_clear_c   = 1'b0;
        tmo_inc_c     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    if (req_write) begin
                        pwdata_d = req_wdata;
                    end
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_clear_c = 1'b1;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    req_ready_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_inc_c = 1'b1;
                    if (tmo_expired_c) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        req_ready_d   = 1'b1;
                        state_d       = IDLE;
                    end
`endif
                end
            end
            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Reset drops any in-flight transfer without a response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
        end else begin
            state_q     <= state_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            paddr       <= paddr_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            pwdata      <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master; timeout steps run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

    logic       pclk;
    logic       presetn;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic       req_write;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [3:0] paddr;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_cmd_master #(
        .ADDR_W         (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic send(input logic [3:0] a, input logic w, input logic [7:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
    endtask

    logic [3:0] bb_addr [3];
    logic [7:0] bb_data [3];

    initial begin
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 4'h0;
        req_write = 1'b0;
        req_wdata = 8'h00;
        prdata    = 8'h00;
        pready    = 1'b1;
        pslverr   = 1'b0;
        bb_addr[0] = 4'h1; bb_data[0] = 8'h11;
        bb_addr[1] = 4'h2; bb_data[1] = 8'h22;
        bb_addr[2] = 4'h4; bb_data[2] = 8'h44;

        // Reset state
        step(); step();
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk8("rst_paddr", 8'(paddr), 8'h00);
        chk8("rst_pwdata", pwdata, 8'h00);
        chk1("rst_pwrite", pwrite, 1'b0);
        chk8("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
        presetn = 1'b1;
        step();
        chk1("rst_req_ready", req_ready, 1'b1);

        // Write, zero wait states; prdata must be ignored for writes
        prdata = 8'hFF;
        send(4'h3, 1'b1, 8'hA5);
        step();
        req_valid = 1'b0;
        chk1("wr_setup_psel", psel, 1'b1);
        chk1("wr_setup_penable", penable, 1'b0);
        chk1("wr_setup_ready", req_ready, 1'b0);
        chk8("wr_setup_paddr", 8'(paddr), 8'h03);
        step();
        chk1("wr_acc_psel", psel, 1'b1);
        chk1("wr_acc_penable", penable, 1'b1);
        chk8("wr_acc_paddr", 8'(paddr), 8'h03);
        chk8("wr_acc_pwdata", pwdata, 8'hA5);
        chk1("wr_acc_pwrite", pwrite, 1'b1);
        chk1("wr_acc_rsp_valid", rsp_valid, 1'b0);
        step();
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk1("wr_rsp_err", rsp_err, 1'b0);
        chk8("wr_rsp_rdata", rsp_rdata, 8'h00);
        chk1("wr_rsp_psel", psel, 1'b0);
        chk1("wr_rsp_ready", req_ready, 1'b1);
        step();
        chk1("wr_pulse_end", rsp_valid, 1'b0);
        chk8("wr_hold_paddr", 8'(paddr), 8'h03);

        // Read with 2 wait states; pslverr during waits is ignored
        pready = 1'b0;
        send(4'hC, 1'b0, 8'h99);
        step();
        req_valid = 1'b0;
        chk1("rd_setup_penable", penable, 1'b0);
        pslverr = 1'b1;
        step();
        chk1("rd_acc1_penable", penable, 1'b1);
        chk8("rd_acc1_paddr", 8'(paddr), 8'h0C);
        chk1("rd_acc1_pwrite", pwrite, 1'b0);
        step();
        chk1("rd_acc2_psel", psel, 1'b1);
        chk8("rd_acc2_paddr", 8'(paddr), 8'h0C);
        chk1("rd_acc2_rsp_valid", rsp_valid, 1'b0);
        step();
        chk8("rd_acc3_paddr", 8'(paddr), 8'h0C);
        chk8("rd_acc3_pwdata", pwdata, 8'hA5);
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 8'h5E;
        step();
        chk1("rd_rsp_valid", rsp_valid, 1'b1);
        chk8("rd_rsp_rdata", rsp_rdata, 8'h5E);
        chk1("rd_rsp_err", rsp_err, 1'b0);
        step();
        chk8("rd_rdata_hold", rsp_rdata, 8'h5E);

        // Slave error on read
        pslverr = 1'b1;
        prdata  = 8'h77;
        send(4'hF, 1'b0, 8'h00);
        step();
        req_valid = 1'b0;
        step();
        chk8("err_paddr", 8'(paddr), 8'h0F);
        step();
        chk1("err_rsp_valid", rsp_valid, 1'b1);
        chk1("err_rsp_err", rsp_err, 1'b1);
        chk1("err_rsp_timeout", rsp_timeout, 1'b0);
        chk8("err_rsp_rdata", rsp_rdata, 8'h77);
        pslverr = 1'b0;
        step();

        // Back-to-back: req_valid held, three writes, one every 3 cycles
        send(bb_addr[0], 1'b1, bb_data[0]);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("bb_setup_psel", psel, 1'b1);
            chk1("bb_setup_penable", penable, 1'b0);
            chk8("bb_setup_paddr", 8'(paddr), 8'(bb_addr[k]));
            chk1("bb_setup_rsp_valid", rsp_valid, 1'b0);
            if (k < 2) send(bb_addr[k+1], 1'b1, bb_data[k+1]);
            else req_valid = 1'b0;
            step();
            chk1("bb_acc_penable", penable, 1'b1);
            chk8("bb_acc_pwdata", pwdata, bb_data[k]);
            chk1("bb_acc_rsp_valid", rsp_valid, 1'b0);
            step();
            chk1("bb_rsp_valid", rsp_valid, 1'b1);
            chk1("bb_gap_psel", psel, 1'b0);
            chk1("bb_rsp_ready", req_ready, 1'b1);
        end
        step();
        chk1("bb_idle_psel", psel, 1'b0);

        // Reset during ACCESS: async clear, no response
        pready = 1'b0;
        send(4'h6, 1'b0, 8'h00);
        step();
        req_valid = 1'b0;
        step();
        chk1("mid_acc_penable", penable, 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk1("mid_rst_psel", psel, 1'b0);
        chk1("mid_rst_penable", penable, 1'b0);
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        step();
        presetn = 1'b1;
        pready  = 1'b1;
        step();
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("post_rst_ready", req_ready, 1'b1);
        send(4'h9, 1'b1, 8'h3C);
        step();
        req_valid = 1'b0;
        chk1("post_rst_rsp_none", rsp_valid, 1'b0);
        step();
        chk8("post_rst_paddr", 8'(paddr), 8'h09);
        step();
        chk1("post_rst_rsp", rsp_valid, 1'b1);
        chk1("post_rst_err", rsp_err, 1'b0);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout after 4 ACCESS cycles without pready
        pready = 1'b0;
        prdata = 8'hEE;
        send(4'h2, 1'b0, 8'h00);
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk1("tmo_acc_psel", psel, 1'b1);
            chk1("tmo_acc_rsp_valid", rsp_valid, 1'b0);
        end
        step();
        chk1("tmo_psel", psel, 1'b0);
        chk1("tmo_penable", penable, 1'b0);
        chk1("tmo_rsp_valid", rsp_valid, 1'b1);
        chk1("tmo_rsp_err", rsp_err, 1'b1);
        chk1("tmo_rsp_timeout", rsp_timeout, 1'b1);
        chk8("tmo_rsp_rdata", rsp_rdata, 8'h00);
        chk1("tmo_ready", req_ready, 1'b1);
        pready = 1'b1;
        step();
`else
        // Without the timeout build a stalled ACCESS never aborts
        pready = 1'b0;
        send(4'h2, 1'b0, 8'h00);
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        chk1("notmo_psel", psel, 1'b1);
        chk1("notmo_penable", penable, 1'b1);
        chk1("notmo_rsp_timeout", rsp_timeout, 1'b0);
        pready = 1'b1;
        prdata = 8'h42;
        step();
        chk1("notmo_rsp_valid", rsp_valid, 1'b1);
        chk8("notmo_rsp_rdata", rsp_rdata, 8'h42);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
